// File: rtl/bitstream_window_accum.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_window_accum
// Description : Counts ones on N_CH bitstreams over a programmable window and
//               reports per-channel counts plus a scaled uni/bipolar total.
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_window_accum #(
    parameter  int N_CH     = 4,
    parameter  int WIN_LOG2 = 4,
    parameter  int SHIFT    = 1,
    localparam int CW       = WIN_LOG2 + 1,
    localparam int SW       = WIN_LOG2 + $clog2(N_CH) + SHIFT + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [N_CH-1:0]   in_bits,
    input  logic [CW-1:0]     win_len,
    input  logic              bipolar,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [SW-1:0]     out_sum,
    output logic [N_CH*CW-1:0] out_cnt,
    output logic              busy,
    output logic              overrun
);

    localparam int C_W_MAX = 1 << WIN_LOG2;

    logic [WIN_LOG2-1:0]       cnt_q, cnt_d;
    logic [N_CH-1:0][CW-1:0]   acc_q, acc_d;
    logic [CW-1:0]             len_q, len_d;
    logic                      mode_q, mode_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic                      out_valid_q, out_valid_d;
    logic [SW-1:0]             out_sum_q, out_sum_d;
    logic [N_CH*CW-1:0]        out_cnt_q, out_cnt_d;

    logic                      first_w;
    logic                      last_w;
    logic [CW-1:0]             eff_len_w;
    logic [CW-1:0]             cur_len_w;
    logic                      cur_mode_w;
    logic [N_CH-1:0][CW-1:0]   acc_new_w;
    logic [SW-1:0]             total_w;
    logic [SW-1:0]             nl_w;
    logic [SW-1:0]             signed_w;
    logic [SW-1:0]             scaled_w;

    // Length and mode come straight from the inputs on the first sample so
    // that a one-sample window uses the freshly programmed values.
    always_comb begin
        first_w    = (cnt_q == '0);
        eff_len_w  = ((win_len == '0) || (win_len > CW'(C_W_MAX))) ? CW'(C_W_MAX) : win_len;
        cur_len_w  = first_w ? eff_len_w : len_q;
        cur_mode_w = first_w ? bipolar : mode_q;
        last_w     = ({1'b0, cnt_q} == (cur_len_w - CW'(1)));
    end

    always_comb begin
        total_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            acc_new_w[i] = (first_w ? CW'(0) : acc_q[i]) + CW'(in_bits[i]);
            total_w      = total_w + SW'(acc_new_w[i]);
        end
        nl_w     = SW'(N_CH) * SW'(cur_len_w);
        signed_w = (total_w << 1) - nl_w;
        scaled_w = (cur_mode_w ? signed_w : total_w) << SHIFT;
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        len_d       = len_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            cnt_d     = '0;
            acc_d     = '0;
            busy_d    = 1'b0;
            overrun_d = 1'b0;
        end else if (in_valid) begin
            if (first_w) begin
                len_d  = eff_len_w;
                mode_d = bipolar;
            end
            if (last_w) begin
                cnt_d       = '0;
                acc_d       = '0;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                out_cnt_d   = acc_new_w;
                out_sum_d   = scaled_w;
                if (out_valid_q && !out_ready) begin
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d  = cnt_q + 1'b1;
                acc_d  = acc_new_w;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            len_q       <= CW'(C_W_MAX);
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: doc/bitstream_window_accum.md
Name: bitstream_window_accum

Overview:
Parametrised successor to the fixed 4-channel, 16-cycle bitstream adder. It counts ones on N_CH one-bit stream inputs over a runtime-programmable window of accepted samples. At the end of each window it reports per-channel counts and a scaled total, in unipolar or bipolar coding. The result is held behind a valid/ready handshake, with overrun detection. It sits between the stochastic-bitstream neuron lanes and the downstream accumulate/activation stage.

Parameters:
N_CH, 4, number of 1-bit input channels (1..32)
WIN_LOG2, 4, log2 of the maximum window length (window max W = 2^WIN_LOG2 samples)
SHIFT, 1, left shift applied to the total (output scale factor 2^SHIFT)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
clr  input  1  synchronous abort: drops current window, clears overrun
in_valid  input  1  in_bits is a sample this cycle
in_bits  input  N_CH  one stream bit per channel, bit i = channel i
win_len  input  WIN_LOG2+1  window length in samples; 0 or >W means W; sampled at window start
bipolar  input  1  0 = unipolar (bit counts +1); 1 = bipolar (1 -> +1, 0 -> -1); sampled at window start
out_ready  input  1  consumer accepts the result
out_valid  output  1  result registers hold an unconsumed window result
out_sum  output  SW  signed two's-complement scaled total, SW = WIN_LOG2 + clog2(N_CH) + SHIFT + 2
out_cnt  output  N_CH*(WIN_LOG2+1)  per-channel ones count, channel i at [i*CW +: CW], CW = WIN_LOG2+1
busy  output  1  a window is in progress (≥1 sample accepted, not yet complete)
overrun  output  1  sticky: a result was overwritten before it was consumed

Behaviour:
- Reset (rst=0, async): sample counter, accumulators, out_sum, out_cnt, out_valid, busy and overrun all 0. The latched length resets to W and the latched mode to unipolar.
- Counter: advances only on in_valid=1. No gap penalty; idle cycles hold all state.
- Window start: the first accepted sample (counter = 0) latches L (effective win_len) and the mode. Changes to win_len or bipolar mid-window are ignored.
- Accumulation: on each accepted sample, acc[i] += in_bits[i]. On the first sample of a window, acc[i] is loaded with in_bits[i], not added. acc[i] is CW bits wide and cannot overflow (max W).
- Window end: the cycle that accepts sample number L (counter = L-1):
  - Next edge loads out_cnt with the final counts (including that sample) and loads out_sum.
  - out_valid is set, counter returns to 0, busy drops.
  - Latency: result visible one clock after the last sample edge.
- Total T = sum of the final acc[i] (unsigned, fits in CW + clog2(N_CH) bits).
- Unipolar: out_sum = T << SHIFT, always non-negative.
- Bipolar: out_sum = (2T - N_CH*L) << SHIFT, signed. Range is ±N_CH*W*2^SHIFT, which fits SW.
- Handshake: out_valid stays high and outputs stay stable until out_ready=1 on a rising edge. Then out_valid clears, unless a new result loads on that same edge.
- Simultaneous out_ready=1 and new result load: the new result loads, out_valid stays 1, no overrun.
- New result load while out_valid=1 and out_ready=0: the new result overwrites, out_valid stays 1, overrun is set (sticky).
- No backpressure on inputs: windows are never stalled.
- clr=1 (sync, highest priority after reset):
  - counter and accumulators go to 0, busy=0, overrun=0.
  - out_valid/out_sum/out_cnt are unchanged, so a pending result is still deliverable.
  - A sample presented with clr=1 is discarded.
- L=1: every accepted sample completes a window. Back-to-back results every valid cycle are legal.
- Reset mid-window: all partial state is lost. After release, the next accepted sample starts a fresh window.

Test Plan:
- N_CH=4, WIN_LOG2=4, SHIFT=1, unipolar, win_len=16, in_valid continuous, in_bits=4'b1111 for 16 cycles, out_ready=1 -> out_valid pulses 1 cycle after 16th sample; out_cnt each = 16; out_sum = 128.
- Bipolar, win_len=8, ch0 all ones, ch1 all zeros, ch2/ch3 alternate starting 1 -> out_cnt = {4,4,0,8}; T=16; out_sum = (32-32)<<1 = 0. Repeat with all zeros -> out_sum = -64.
- win_len=5 with in_valid toggling 1/0 -> result only after the 5th accepted sample (cycle 9 of stimulus); the idle cycles do not change acc.
- out_ready=0 across two complete windows -> overrun=1 after second load, out_sum equals second window. Then assert clr -> overrun=0, out_valid still 1 until out_ready.
- win_len=1, continuous valid, out_ready=1 -> out_valid high every cycle after the first, out_cnt tracks in_bits with 1-cycle delay, overrun stays 0.
- Assert rst low mid-window (after 7 of 16 samples) -> all outputs 0 immediately. After release, a full 16-sample window of ones gives exactly out_sum=128.
